// File: rtl/fu_alu_wb_if.sv
// fu_alu_wb_if: ALU-result producer and writeback-consumer handshakes
// for the ALU writeback buffer.
interface fu_alu_wb_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [31:0] alu_result;
    logic        alu_negative;
    logic        alu_overflow;
    logic        alu_zero;
    logic [4:0]  alu_rd;
    logic        alu_rd_we;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [2:0]  wb_flags;

    // Buffer side: takes ALU results, drives writeback
    modport slave (
        input  alu_valid, alu_result, alu_negative,
        input  alu_overflow, alu_zero, alu_rd, alu_rd_we,
        input  wb_ready,
        output alu_ready,
        output wb_valid, wb_data, wb_rd, wb_we, wb_flags
    );

    // Environment side: ALU producer and writeback consumer
    modport master (
        output alu_valid, alu_result, alu_negative,
        output alu_overflow, alu_zero, alu_rd, alu_rd_we,
        output wb_ready,
        input  alu_ready,
        input  wb_valid, wb_data, wb_rd, wb_we, wb_flags
    );
endinterface

// File: rtl/fu_alu_wb.sv
// fu_alu_wb: in-order result buffer between ALU and register writeback.
// Registered only; no combinational path from ALU inputs to wb outputs.
module fu_alu_wb #(
    parameter int DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_err,
    fu_alu_wb_if.slave               bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_data  [DEPTH];
    logic [2:0]    r_flags [DEPTH];
    logic [4:0]    r_rd    [DEPTH];
    logic          r_we    [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_drop;

    logic          w_full;
    logic          w_valid;
    logic          w_enq;
    logic          w_deq;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_valid  = (r_count != '0) && nRST;
    assign w_enq    = bus.alu_valid && bus.alu_ready && !flush;
    assign w_deq    = w_valid && bus.wb_ready;

    assign bus.alu_ready = !w_full && nRST;
    assign bus.wb_valid  = w_valid;
    assign count         = r_count;
    assign drop_err      = r_drop;

    // Head entry presented to writeback, zeroed when nothing is valid
    always_comb begin
        bus.wb_data  = '0;
        bus.wb_rd    = '0;
        bus.wb_we    = 1'b0;
        bus.wb_flags = '0;
        if (w_valid) begin
            bus.wb_data  = r_data[r_rptr];
            bus.wb_rd    = r_rd[r_rptr];
            bus.wb_we    = r_we[r_rptr] && (r_rd[r_rptr] != 5'd0);
            bus.wb_flags = r_flags[r_rptr];
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_data[r_wptr]  <= bus.alu_result;
            r_flags[r_wptr] <= {bus.alu_negative,
                                bus.alu_overflow,
                                bus.alu_zero};
            r_rd[r_wptr]    <= bus.alu_rd;
            r_we[r_wptr]    <= bus.alu_rd_we;
        end
    end

    // Pointers and occupancy; flush empties without completing enqueue
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq)
                r_wptr <= r_wptr + AW'(1);
            if (w_deq)
                r_rptr <= r_rptr + AW'(1);
            if (w_enq && !w_deq)
                r_count <= r_count + CW'(1);
            else if (!w_enq && w_deq)
                r_count <= r_count - CW'(1);
        end
    end

    // Sticky record of a result offered while the buffer was full
    always_ff @(posedge CLK) begin
        if (!nRST)
            r_drop <= 1'b0;
        else if (bus.alu_valid && !bus.alu_ready && !flush)
            r_drop <= 1'b1;
    end
endmodule

// File: tb/tb_fu_alu_wb.sv
// tb_fu_alu_wb: directed checks of the ALU writeback buffer (DEPTH=2).
// Inputs change 1ns after each rising edge; outputs sampled there too.
module tb_fu_alu_wb;
  logic       CLK;
  logic       nRST;
  logic       flush;
  logic [1:0] count;
  logic       drop_err;
  int         checks;
  int         errors;

  fu_alu_wb_if bus ();

  fu_alu_wb #(.DEPTH(2)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .flush    (flush),
    .count    (count),
    .drop_err (drop_err),
    .bus      (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic offer(input logic v, input logic [31:0] d,
                       input logic [4:0] rd, input logic we,
                       input logic [2:0] fl);
    bus.alu_valid    = v;
    bus.alu_result   = d;
    bus.alu_rd       = rd;
    bus.alu_rd_we    = we;
    bus.alu_negative = fl[2];
    bus.alu_overflow = fl[1];
    bus.alu_zero     = fl[0];
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRST = 1'b0;
    flush = 1'b0;
    bus.wb_ready = 1'b0;
    offer(1'b0, 32'h0, 5'd0, 1'b0, 3'b000);

    tick();
    offer(1'b1, 32'h99, 5'd1, 1'b1, 3'b000);
    tick();
    chk("rst_count", count, 2'd0);
    chk("rst_drop", drop_err, 1'b0);
    chk("rst_ready", bus.alu_ready, 1'b0);
    chk("rst_wbv", bus.wb_valid, 1'b0);
    chk("rst_wbd", bus.wb_data, 32'h0);
    offer(1'b0, 32'h0, 5'd0, 1'b0, 3'b000);
    nRST = 1'b1;
    #1;
    chk("rel_ready", bus.alu_ready, 1'b1);

    bus.wb_ready = 1'b1;
    offer(1'b1, 32'hDEADBEEF, 5'd5, 1'b1, 3'b100);
    tick();
    offer(1'b0, 32'h0, 5'd0, 1'b0, 3'b000);
    chk("sp_wbv", bus.wb_valid, 1'b1);
    chk("sp_data", bus.wb_data, 32'hDEADBEEF);
    chk("sp_rd", bus.wb_rd, 5'd5);
    chk("sp_we", bus.wb_we, 1'b1);
    chk("sp_flags", bus.wb_flags, 3'b100);
    chk("sp_cnt1", count, 2'd1);
    tick();
    chk("sp_cnt0", count, 2'd0);
    chk("sp_wbv0", bus.wb_valid, 1'b0);
    chk("sp_data0", bus.wb_data, 32'h0);

    bus.wb_ready = 1'b0;
    offer(1'b1, 32'h1, 5'd1, 1'b1, 3'b000);
    tick();
    chk("fl_ready1", bus.alu_ready, 1'b1);
    offer(1'b1, 32'h2, 5'd2, 1'b1, 3'b000);
    tick();
    chk("fl_ready0", bus.alu_ready, 1'b0);
    chk("fl_cnt2", count, 2'd2);
    chk("fl_drop0", drop_err, 1'b0);
    offer(1'b1, 32'h3, 5'd3, 1'b1, 3'b000);
    tick();
    chk("fl_drop1", drop_err, 1'b1);
    chk("fl_cnt2b", count, 2'd2);
    offer(1'b0, 32'h0, 5'd0, 1'b0, 3'b000);
    bus.wb_ready = 1'b1;
    #1;
    chk("fl_out1", bus.wb_data, 32'h1);
    tick();
    chk("fl_out2", bus.wb_data, 32'h2);
    chk("fl_cnt1", count, 2'd1);
    tick();
    chk("fl_cnt0", count, 2'd0);
    chk("fl_empty", bus.wb_valid, 1'b0);

    bus.wb_ready = 1'b0;
    offer(1'b1, 32'hA, 5'd1, 1'b1, 3'b000);
    tick();
    offer(1'b1, 32'hB, 5'd2, 1'b1, 3'b000);
    tick();
    chk("fd_cnt2", count, 2'd2);
    offer(1'b1, 32'hC, 5'd3, 1'b1, 3'b000);
    bus.wb_ready = 1'b1;
    #1;
    chk("fd_ready0", bus.alu_ready, 1'b0);
    tick();
    chk("fd_cnt1", count, 2'd1);
    chk("fd_head", bus.wb_data, 32'hB);
    chk("fd_ready1", bus.alu_ready, 1'b1);
    bus.wb_ready = 1'b0;
    tick();
    chk("fd_cnt2b", count, 2'd2);
    offer(1'b0, 32'h0, 5'd0, 1'b0, 3'b000);
    bus.wb_ready = 1'b1;
    tick();
    chk("fd_headC", bus.wb_data, 32'hC);
    tick();
    chk("fd_cnt0", count, 2'd0);

    bus.wb_ready = 1'b0;
    offer(1'b1, 32'h55, 5'd0, 1'b1, 3'b001);
    tick();
    offer(1'b0, 32'h0, 5'd0, 1'b0, 3'b000);
    chk("x0_wbv", bus.wb_valid, 1'b1);
    chk("x0_data", bus.wb_data, 32'h55);
    chk("x0_we", bus.wb_we, 1'b0);
    chk("x0_flags", bus.wb_flags, 3'b001);
    bus.wb_ready = 1'b1;
    tick();
    chk("x0_cnt0", count, 2'd0);

    bus.wb_ready = 1'b0;
    offer(1'b1, 32'h11, 5'd1, 1'b1, 3'b000);
    tick();
    offer(1'b1, 32'h22, 5'd2, 1'b1, 3'b000);
    tick();
    chk("fls_cnt2", count, 2'd2);
    offer(1'b1, 32'h33, 5'd3, 1'b1, 3'b000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, 32'h0, 5'd0, 1'b0, 3'b000);
    chk("fls_cnt0", count, 2'd0);
    chk("fls_wbv", bus.wb_valid, 1'b0);

    offer(1'b1, 32'h44, 5'd4, 1'b1, 3'b000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fls2_cnt0", count, 2'd0);
    offer(1'b1, 32'h66, 5'd6, 1'b1, 3'b000);
    tick();
    offer(1'b0, 32'h0, 5'd0, 1'b0, 3'b000);
    chk("fls_post", bus.wb_data, 32'h66);
    bus.wb_ready = 1'b1;
    tick();
    chk("fls_post0", count, 2'd0);

    bus.wb_ready = 1'b0;
    offer(1'b1, 32'h12, 5'd1, 1'b1, 3'b000);
    tick();
    offer(1'b1, 32'h34, 5'd2, 1'b1, 3'b000);
    tick();
    offer(1'b1, 32'h56, 5'd3, 1'b1, 3'b000);
    nRST = 1'b0;
    #1;
    chk("mr_ready", bus.alu_ready, 1'b0);
    chk("mr_wbv", bus.wb_valid, 1'b0);
    chk("mr_wbd", bus.wb_data, 32'h0);
    tick();
    chk("mr_cnt0", count, 2'd0);
    chk("mr_drop0", drop_err, 1'b0);
    nRST = 1'b1;
    offer(1'b1, 32'h77, 5'd7, 1'b1, 3'b010);
    #1;
    chk("mr_ready1", bus.alu_ready, 1'b1);
    tick();
    offer(1'b0, 32'h0, 5'd0, 1'b0, 3'b000);
    chk("mr_cnt1", count, 2'd1);
    chk("mr_data", bus.wb_data, 32'h77);
    chk("mr_flags", bus.wb_flags, 3'b010);
    bus.wb_ready = 1'b1;
    tick();
    chk("mr_cnt0b", count, 2'd0);

    bus.wb_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(1'b1, 32'(i), 5'd9, 1'b1, 3'b000);
      tick();
      chk("wr_data", bus.wb_data, 32'(i));
      chk("wr_cnt", count, 2'd1);
    end
    offer(1'b0, 32'h0, 5'd0, 1'b0, 3'b000);
    tick();
    chk("wr_cnt0", count, 2'd0);
    chk("wr_drop", drop_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/fu_alu_wb.md
FU_ALU_WB -- requirements
Module: fu_alu_wb

Interface
REQ-001 Parameter DEPTH, default 2, result-buffer entries; legal values 2, 4, 8.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset, synchronous, active-low.
REQ-004 alu_valid  input  1  ALU result presented this cycle.
REQ-005 alu_ready  output  1  buffer accepts a result this cycle.
REQ-006 alu_result  input  32  ALU port_output (word_t).
REQ-007 alu_negative, alu_overflow, alu_zero  input  1 each  ALU flags.
REQ-008 alu_rd  input  5  destination register index.
REQ-009 alu_rd_we  input  1  instruction writes rd.
REQ-010 flush  input  1  discard all buffered and incoming results.
REQ-011 wb_valid  output  1  head entry presented to writeback.
REQ-012 wb_ready  input  1  writeback consumes head this cycle.
REQ-013 wb_data  output  32  head result.
REQ-014 wb_rd  output  5  head destination index.
REQ-015 wb_we  output  1  head register-write enable.
REQ-016 wb_flags  output  3  head {negative, overflow, zero}.
REQ-017 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-018 drop_err  output  1  sticky: a result was offered while not accepted.

Function
REQ-019 Block SHALL be an in-order FIFO of DEPTH entries {result, flags, rd, rd_we}.
REQ-020 alu_ready SHALL equal (count != DEPTH) && nRST; independent of wb_ready (no full-bypass).
REQ-021 Enqueue SHALL occur on an edge where alu_valid && alu_ready && !flush.
REQ-022 wb_valid SHALL equal (count != 0); dequeue on an edge where wb_valid && wb_ready.
REQ-023 Latency: result enqueued at edge N SHALL appear on wb_* from edge N onward (visible cycle N+1); no combinational alu->wb path.
REQ-024 Simultaneous enqueue and dequeue SHALL leave count unchanged and preserve order.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; full/empty derived from count, not pointer equality.
REQ-026 wb_we SHALL equal stored rd_we && (stored rd != 0); x0 writes suppressed, entry still delivered.
REQ-027 wb_data, wb_rd, wb_we, wb_flags SHALL be 0 when wb_valid is 0.
REQ-028 flush at an edge SHALL set count 0 and both pointers 0; concurrent enqueue dropped; concurrent dequeue handshake treated as completed by downstream.
REQ-029 drop_err SHALL set on an edge where alu_valid && !alu_ready && !flush && nRST; cleared only by reset.
REQ-030 Offered-but-not-accepted results SHALL cause no FIFO state change.
REQ-031 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-032 On an edge with nRST=0: count=0, pointers=0, drop_err=0; storage contents need not be cleared.
REQ-033 While nRST=0: alu_ready=0, wb_valid=0, all wb_* outputs 0.
REQ-034 Reset asserted mid-operation SHALL discard all entries; first accept possible on the cycle after nRST returns high.

Verification
REQ-035 Single pass: enqueue {0xDEADBEEF, rd=5, we=1, flags=100}, wb_ready=1 -> next cycle wb_valid=1, wb_data=0xDEADBEEF, wb_rd=5, wb_we=1, wb_flags=3'b100; count returns 0 after dequeue.
REQ-036 Fill/backpressure (DEPTH=2): wb_ready=0, offer 3 results 0x1,0x2,0x3 -> alu_ready=0 after second, count=2, drop_err=1; release wb_ready -> outputs 0x1 then 0x2, 0x3 never appears.
REQ-037 Full with simultaneous offer and dequeue: count=2, alu_valid=1, wb_ready=1 -> no enqueue that edge (alu_ready=0), count=1; next cycle enqueue accepted.
REQ-038 x0 suppression: enqueue rd=0, rd_we=1, result 0x55 -> wb_valid=1, wb_data=0x55, wb_we=0.
REQ-039 Flush and reset: 2 entries buffered, flush=1 with alu_valid=1 -> count=0, wb_valid=0 next cycle, offered result lost; repeat with nRST=0 -> same plus drop_err cleared, alu_ready=0 during reset.
REQ-040 Wrap-around: 10 back-to-back enqueue/dequeue pairs with incrementing data 0..9 -> wb_data sequence 0..9 in order, count stays ≤1.
